// File: rtl/reaction_pkg.sv
// Shared constants, state encoding and LFSR step for the reaction timer.
package reaction_pkg;

    localparam int unsigned ELAPSED_W     = 14;
    localparam int unsigned MAX_COUNT_DEF = 9999;
    localparam int unsigned LFSR_W        = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;
    // Taps 16,14,13,11 as bit positions 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RUN   = 2'd2,
        ST_HELD  = 2'd3
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// Strobe/status bundle between the reaction-test control FSM and the timer.
interface reaction_timer_if
    import reaction_pkg::*;
();

    logic                 arm_delay;
    logic                 start_timer;
    logic                 stop_timer;
    logic                 clear;
    logic                 delay_done;
    logic [ELAPSED_W-1:0] elapsed_time;
    logic                 running;
    logic                 overflow;

    modport master (
        output arm_delay, start_timer, stop_timer, clear,
        input  delay_done, elapsed_time, running, overflow
    );

    modport slave (
        input  arm_delay, start_timer, stop_timer, clear,
        output delay_done, elapsed_time, running, overflow
    );

endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler with synchronous restart; tick is high in the last cycle of each ms.
module ms_tick_gen #(
    parameter int unsigned TICKS_PER_MS = 10_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic ms_tick_c
);

    localparam int unsigned CNT_W = $clog2(TICKS_PER_MS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_MS - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign ms_tick_c = (cnt == CNT_LAST);

endmodule

// File: rtl/reaction_timer.sv
// Random foreperiod generator and ms reaction counter for the reaction-test FSM.
// Define RANDOM_DELAY_EN to add an LFSR-based random extension to the foreperiod.
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int unsigned       CLK_HZ       = 10_000_000,
    parameter int unsigned       MIN_DELAY_MS = 1000,
    parameter int unsigned       RANGE_BITS   = 11,
    parameter int unsigned       MAX_COUNT    = MAX_COUNT_DEF,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_SEED_DEF
) (
    input logic             clk,
    input logic             rst_n,
    reaction_timer_if.slave bus
);

    localparam int unsigned TICKS_PER_MS = CLK_HZ / 1000;
    localparam int unsigned TARGET_W     = $clog2(MIN_DELAY_MS + (1 << RANGE_BITS));

    if (TICKS_PER_MS < 2) begin : g_bad_clk
        $error("reaction_timer: CLK_HZ must give at least 2 ticks per ms");
    end
    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("reaction_timer: LFSR_SEED must be nonzero");
    end

    state_e               state, state_nx;
    logic [TARGET_W-1:0]  remain, remain_nx;
    logic [ELAPSED_W-1:0] elapsed, elapsed_nx;
    logic                 ov, ov_nx;
    logic                 done, done_nx;
    logic                 running;
    logic                 restart_c;
    logic                 ms_tick_c;
    logic                 at_max_c;
    logic [TARGET_W-1:0]  target_c;

    ms_tick_gen #(.TICKS_PER_MS(TICKS_PER_MS)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart_c),
        .ms_tick_c (ms_tick_c)
    );

`ifdef RANDOM_DELAY_EN
    // Free-running so the sampled value depends on when the user presses the button
    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign target_c = TARGET_W'(MIN_DELAY_MS) + TARGET_W'(lfsr[RANGE_BITS-1:0]);
`else
    assign target_c = TARGET_W'(MIN_DELAY_MS);
`endif

    assign at_max_c = (elapsed >= ELAPSED_W'(MAX_COUNT - 1));

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            remain  <= '0;
            elapsed <= '0;
            ov      <= 1'b0;
            done    <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_nx;
            remain  <= remain_nx;
            elapsed <= elapsed_nx;
            ov      <= ov_nx;
            done    <= done_nx;
            running <= (state_nx == ST_RUN);
        end
    end

    // Next state: clear > start > stop (RUN only) > arm (IDLE/HELD only) > per-state work
    always_comb begin
        state_nx   = state;
        remain_nx  = remain;
        elapsed_nx = elapsed;
        ov_nx      = ov;
        done_nx    = 1'b0;
        restart_c  = 1'b0;

        if (bus.clear) begin
            state_nx   = ST_IDLE;
            remain_nx  = '0;
            elapsed_nx = '0;
            ov_nx      = 1'b0;
        end else if (bus.start_timer) begin
            state_nx   = ST_RUN;
            remain_nx  = '0;
            elapsed_nx = '0;
            ov_nx      = 1'b0;
            restart_c  = 1'b1;
        end else if (bus.stop_timer && (state == ST_RUN)) begin
            state_nx = ST_HELD;
            if (ms_tick_c) begin
                elapsed_nx = at_max_c ? ELAPSED_W'(MAX_COUNT) : elapsed + ELAPSED_W'(1);
                ov_nx      = ov | at_max_c;
            end
        end else if (bus.arm_delay && ((state == ST_IDLE) || (state == ST_HELD))) begin
            state_nx  = ST_DELAY;
            remain_nx = target_c;
            restart_c = 1'b1;
        end else begin
            case (state)
                ST_DELAY: begin
                    if (ms_tick_c) begin
                        if (remain <= TARGET_W'(1)) begin
                            state_nx  = ST_IDLE;
                            remain_nx = '0;
                            done_nx   = 1'b1;
                        end else begin
                            remain_nx = remain - TARGET_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (ms_tick_c) begin
                        elapsed_nx = at_max_c ? ELAPSED_W'(MAX_COUNT) : elapsed + ELAPSED_W'(1);
                        ov_nx      = ov | at_max_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.delay_done   = done;
    assign bus.elapsed_time = elapsed;
    assign bus.running      = running;
    assign bus.overflow     = ov;

endmodule
